// File: rtl/instruction_decode.sv
// Decode stage: turns a fetched 16-bit instruction into a registered 19-bit
// packet for the register-read stage.
// Optional LM/SM micro-op expansion is built only when LMSM_EXPAND_EN is
// defined. Without it, LM/SM decode as bubbles and busy is tied low.
module instruction_decode (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        stall,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        busy,
  output logic [18:0] out_data
);

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  // Packet type for each opcode; 2'b00 means the opcode is not recognised.
  function automatic logic [1:0] op_type(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0010:                            op_type = 2'b11;
      4'b0001, 4'b0100, 4'b0101, 4'b1100, 4'b1001: op_type = 2'b10;
      4'b0011, 4'b1000:                            op_type = 2'b01;
      default:                                     op_type = 2'b00;
    endcase
  endfunction

  logic [18:0] plain_pkt;

  // Build the packet for an ordinary instruction, or a bubble for an unknown opcode.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    plain_pkt = '0;
    if (op_type(instr[15:12]) != 2'b00)
      plain_pkt = {instr[11:0], instr[15:12], 1'b0, op_type(instr[15:12])};
  end

`ifdef LMSM_EXPAND_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_MULTI = 1'b1;

  logic [0:0]  state_q;
  logic [2:0]  base_q;
  logic [7:0]  mask_q;   // mask bits not yet emitted
  logic [2:0]  cnt_q;    // micro-ops already emitted for this instruction
  logic        sm_q;     // 1 = SM, 0 = LM

  logic        is_lmsm;
  logic [7:0]  sel_mask;
  logic [7:0]  rem_mask;
  logic [2:0]  k;
  logic [2:0]  cur_base;
  logic [2:0]  cur_cnt;
  logic [3:0]  cur_op;
  logic [18:0] micro_pkt;

  assign is_lmsm = in_valid && ((instr[15:12] == OP_LM) || (instr[15:12] == OP_SM));
  assign busy    = (state_q == S_MULTI);

  // Select the lowest pending mask bit and format its micro-op.
  // In IDLE the source is the incoming instruction; in MULTI it is the latched copy.
  always_comb begin
    if (state_q == S_MULTI) begin
      sel_mask = mask_q;
      cur_base = base_q;
      cur_cnt  = cnt_q;
      cur_op   = {3'b011, sm_q};
    end else begin
      sel_mask = instr[7:0];
      cur_base = instr[11:9];
      cur_cnt  = 3'd0;
      cur_op   = instr[15:12];
    end
    k = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (sel_mask[i]) k = 3'(i);
    rem_mask  = sel_mask & ~(8'd1 << k);
    micro_pkt = {cur_base, k, 3'b000, cur_cnt, cur_op, (rem_mask == 8'd0), 2'b10};
  end

  // Stage register plus expansion FSM: flush overrides stall, and stall freezes everything.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_data <= '0;
      state_q  <= S_IDLE;
      base_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      sm_q     <= 1'b0;
    end else if (flush) begin
      out_data <= '0;
      state_q  <= S_IDLE;
      mask_q   <= '0;
    end else if (!stall) begin
      if (state_q == S_MULTI) begin
        out_data <= micro_pkt;
        mask_q   <= rem_mask;
        cnt_q    <= cnt_q + 3'd1;
        if (rem_mask == 8'd0) state_q <= S_IDLE;
      end else if (is_lmsm) begin
        if (instr[7:0] == 8'd0) begin
          out_data <= '0;
        end else begin
          out_data <= micro_pkt;
          if (rem_mask != 8'd0) begin
            state_q <= S_MULTI;
            base_q  <= instr[11:9];
            mask_q  <= rem_mask;
            cnt_q   <= 3'd1;
            sm_q    <= instr[12];
          end
        end
      end else begin
        out_data <= in_valid ? plain_pkt : '0;
      end
    end
  end
`else
  assign busy = 1'b0;

  // Stage register: flush overrides stall, and stall holds the packet.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        out_data <= '0;
    else if (flush)     out_data <= '0;
    else if (!stall)    out_data <= in_valid ? plain_pkt : '0;
  end
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
// Expected packets are hand-computed; LM/SM expectations follow LMSM_EXPAND_EN.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        busy;
  logic [18:0] out_data;

  int checks = 0;
  int errors = 0;

  instruction_decode dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .stall    (stall),
    .in_valid (in_valid),
    .instr    (instr),
    .busy     (busy),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset takes effect without a clock edge.
    #2 resetn = 1'b0;
    #1;
    check("reset_out",  out_data, 19'h00000);
    check("reset_busy", {18'd0, busy}, 19'd0);
    #2 resetn = 1'b1;

    // Ordinary decode.
    in_valid = 1'b1; instr = 16'h0298; step();
    check("add_out",  out_data, 19'h14C03);
    check("add_busy", {18'd0, busy}, 19'd0);
    instr = 16'h1ABC; step();
    check("adi_out", out_data, 19'h55E0A);
    instr = 16'h3FFF; step();
    check("lhi_out", out_data, 19'h7FF99);
    instr = 16'h2000; step();
    check("ndu_out", out_data, 19'h00013);
    instr = 16'h8001; step();
    check("jal_out", out_data, 19'h000C1);
    instr = 16'hF123; step();
    check("op1111_bubble", out_data, 19'h00000);
    instr = 16'h0298; in_valid = 1'b0; step();
    check("invalid_bubble", out_data, 19'h00000);

`ifdef LMSM_EXPAND_EN
    // LM R5, mask 0x05: two micro-ops; instr/in_valid ignored during MULTI.
    in_valid = 1'b1; instr = 16'h6A05; step();
    check("lm_uop0",      out_data, 19'h50032);
    check("lm_uop0_busy", {18'd0, busy}, 19'd1);
    instr = 16'hF123; in_valid = 1'b0; step();
    check("lm_uop1",      out_data, 19'h540B6);
    check("lm_uop1_busy", {18'd0, busy}, 19'd0);
    step();
    check("lm_after_idle", out_data, 19'h00000);

    // SM R1, mask 0x82: bits 1 and 7, imm6 counts lower set bits.
    in_valid = 1'b1; instr = 16'h7282; step();
    check("sm_uop0",      out_data, 19'h1203A);
    check("sm_uop0_busy", {18'd0, busy}, 19'd1);
    in_valid = 1'b0; step();
    check("sm_uop1",      out_data, 19'h1E0BE);
    check("sm_uop1_busy", {18'd0, busy}, 19'd0);
`else
    in_valid = 1'b1; instr = 16'h6A05; step();
    check("lm_disabled",      out_data, 19'h00000);
    check("lm_disabled_busy", {18'd0, busy}, 19'd0);
    instr = 16'h7282; step();
    check("sm_disabled", out_data, 19'h00000);
`endif

    // LM with empty mask: single bubble, stays idle.
    in_valid = 1'b1; instr = 16'h6A00; step();
    check("lm_mask0",      out_data, 19'h00000);
    check("lm_mask0_busy", {18'd0, busy}, 19'd0);
    instr = 16'h0298; step();
    check("after_mask0_add", out_data, 19'h14C03);

    // Flush after the first micro-op kills the expansion.
    instr = 16'h6A05; step();
`ifdef LMSM_EXPAND_EN
    check("flush_uop0", out_data, 19'h50032);
`else
    check("flush_uop0", out_data, 19'h00000);
`endif
    in_valid = 1'b0; flush = 1'b1; step();
    check("flush_out",  out_data, 19'h00000);
    check("flush_busy", {18'd0, busy}, 19'd0);
    flush = 1'b0; step();
    check("flush_no_uop1", out_data, 19'h00000);
    check("flush_idle",    {18'd0, busy}, 19'd0);

    // Stall holds the packet and state for three cycles.
`ifdef LMSM_EXPAND_EN
    in_valid = 1'b1; instr = 16'h6A05; step();
    check("stall_uop0", out_data, 19'h50032);
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold",      out_data, 19'h50032);
      check("stall_hold_busy", {18'd0, busy}, 19'd1);
    end
    stall = 1'b0; step();
    check("stall_resume",      out_data, 19'h540B6);
    check("stall_resume_busy", {18'd0, busy}, 19'd0);
`else
    in_valid = 1'b1; instr = 16'h0298; step();
    check("stall_first", out_data, 19'h14C03);
    instr = 16'h1ABC; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", out_data, 19'h14C03);
    end
    stall = 1'b0; step();
    check("stall_resume", out_data, 19'h55E0A);
`endif

    // Flush wins over stall.
    in_valid = 1'b1; instr = 16'h0298; step();
    check("prio_pre", out_data, 19'h14C03);
    stall = 1'b1; flush = 1'b1; step();
    check("flush_over_stall", out_data, 19'h00000);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-expansion, then normal decode resumes.
    instr = 16'h6A05; step();
`ifdef LMSM_EXPAND_EN
    check("rst_uop0",      out_data, 19'h50032);
    check("rst_uop0_busy", {18'd0, busy}, 19'd1);
`else
    check("rst_uop0", out_data, 19'h00000);
`endif
    in_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("midrst_out",  out_data, 19'h00000);
    check("midrst_busy", {18'd0, busy}, 19'd0);
    #2 resetn = 1'b1;
    in_valid = 1'b1; instr = 16'h0298; step();
    check("post_rst_add",  out_data, 19'h14C03);
    check("post_rst_busy", {18'd0, busy}, 19'd0);
    in_valid = 1'b0; step();
    check("post_rst_idle", out_data, 19'h00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush, input, 1, synchronous pipeline kill.
REQ-004 SHALL have port stall, input, 1, hold stage contents.
REQ-005 SHALL have port in_valid, input, 1, instr is valid.
REQ-006 SHALL have port instr, input, 16, fetched instruction: [15:12] opcode, [11:9] A, [8:6] B, [5:3] C, [5:0] imm6, [8:0] imm9, [7:0] LM/SM mask.
REQ-007 SHALL have port busy, output, 1, high while expanding LM/SM; fetch holds instr and in_valid while high.
REQ-008 SHALL have port out_data, output, 19, registered packet to the register-read stage.
REQ-009 SHALL use this packet format: [18:16] regA, [15:13] regB, [12:10] regC, [12:7] imm6, [15:7] imm9, [6:3] opcode, [2] last micro-op, [1:0] type (11 R, 10 I, 01 J, 00 bubble).

Function
REQ-010 SHALL register out_data with 1-cycle latency from accepted instr.
REQ-011 SHALL, for non-LM/SM instructions, set [18:7]=instr[11:0], [6:3]=instr[15:12], [2]=0.
REQ-012 SHALL classify type: 0000 ADD, 0010 NDU -> 11; 0001 ADI, 0100 LW, 0101 SW, 1100 BEQ, 1001 JLR -> 10; 0011 LHI, 1000 JAL -> 01.
REQ-013 SHALL emit all-zero bubble for unlisted opcodes and when in_valid=0 in IDLE.
REQ-014 SHALL implement FSM IDLE/MULTI; reset state IDLE; busy = (state==MULTI).
REQ-015 SHALL, in IDLE with valid LM (0110) or SM (0111) and non-zero mask, latch base A and mask, and emit the micro-op for the lowest set bit.
REQ-016 SHALL format micro-op k as: regA=base, regB=k, imm6=count of set mask bits below k, opcode as instr, [2]=1 only for highest set bit, type 10.
REQ-017 SHALL move IDLE->MULTI if more set bits remain, emitting one micro-op per cycle in ascending k; MULTI->IDLE after emitting the [2]=1 micro-op.
REQ-018 SHALL ignore instr and in_valid while in MULTI.
REQ-019 SHALL emit a single bubble for LM/SM with mask 0x00 and stay IDLE.
REQ-020 SHALL, on stall=1 without flush, hold out_data, state, and the latched mask unchanged.
REQ-021 SHALL, on flush=1, set out_data=0 and state IDLE at the next edge, with priority over stall and over any in-progress expansion.

Reset
REQ-022 SHALL, on resetn=0, immediately set out_data=0, state IDLE, busy=0, and clear the latched base and mask, including mid-expansion.
REQ-023 SHALL resume decoding on the first rising edge after resetn deasserts.

Configuration
REQ-024 SHALL compile LM/SM expansion only when macro LMSM_EXPAND_EN is defined.
REQ-025 SHALL, without LMSM_EXPAND_EN, decode opcodes 0110/0111 as bubbles, remove the FSM, and tie busy to 0.

Verification
REQ-026 SHALL check ADD R1,R2,R3: instr=0x0298, in_valid=1 -> out_data=0x14C03 next cycle, busy=0.
REQ-027 SHALL check LM R5 mask 0x05: instr=0x6A05 -> out_data=0x50032 with busy=1, then 0x540B6 with busy=0.
REQ-028 SHALL check LM with mask 0x05 and flush=1 after the first micro-op -> out_data=0, busy=0, and the second micro-op is never emitted.
REQ-029 SHALL check stall=1 for 3 cycles during MULTI -> out_data is held and expansion resumes unchanged afterward.
REQ-030 SHALL check resetn pulsed low mid-expansion -> out_data=0 and busy=0 immediately; the next ADD decodes normally.
REQ-031 SHALL check opcode 1111 or in_valid=0 -> out_data=0x00000.
